// File: rtl/wb_queue.sv
// Write-back queue: FIFO of {addr,data} that drains one register-file write per cycle.
// WB_QUEUE_BYPASS_EN adds combinational lookup forwarding of the youngest pending data.
// Latency: accept at edge N, we3 high during cycle N+1. Backpressure: req_ready low only when full.
module wb_queue #(
    parameter int ADDR_WDTH = 5,
    parameter int DATA_WDTH = 32,
    parameter int DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [ADDR_WDTH-1:0]         req_addr,
    input  logic [DATA_WDTH-1:0]         req_data,
    input  logic                         wb_stall,
    output logic                         we3,
    output logic [ADDR_WDTH-1:0]         ad3,
    output logic [DATA_WDTH-1:0]         wd3,
    input  logic [ADDR_WDTH-1:0]         la1,
    input  logic [ADDR_WDTH-1:0]         la2,
    output logic                         hit1,
    output logic                         hit2,
    output logic [DATA_WDTH-1:0]         hd1,
    output logic [DATA_WDTH-1:0]         hd2,
    output logic [$clog2(DEPTH):0]       count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [ADDR_WDTH-1:0] addr;
        logic [DATA_WDTH-1:0] data;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;

    // Writes to register 0 are handshaked but dropped, so they never occupy a slot.
    always_comb begin
        req_ready = (count_q != CW'(DEPTH));
        pop       = (count_q != '0) && !wb_stall;
        push      = req_valid && req_ready && (req_addr != '0);
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        mem_d     = mem_q;
        if (push) begin
            mem_d[tail_q] = '{addr: req_addr, data: req_data};
            tail_d        = tail_q + 1'b1;
        end
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign we3   = pop;
    assign ad3   = (count_q != '0) ? mem_q[head_q].addr : '0;
    assign wd3   = (count_q != '0) ? mem_q[head_q].data : '0;
    assign count = count_q;

`ifdef WB_QUEUE_BYPASS_EN
    logic [PW-1:0] lk_idx;

    // Scan oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        hit1   = 1'b0;
        hit2   = 1'b0;
        hd1    = '0;
        hd2    = '0;
        lk_idx = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            lk_idx = head_q + PW'(i);
            if (CW'(i) < count_q) begin
                if ((la1 != '0) && (mem_q[lk_idx].addr == la1)) begin
                    hit1 = 1'b1;
                    hd1  = mem_q[lk_idx].data;
                end
                if ((la2 != '0) && (mem_q[lk_idx].addr == la2)) begin
                    hit2 = 1'b1;
                    hd2  = mem_q[lk_idx].data;
                end
            end
        end
    end
`else
    logic unused_la;
    assign unused_la = ^{la1, la2};
    assign hit1      = 1'b0;
    assign hit2      = 1'b0;
    assign hd1       = '0;
    assign hd2       = '0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Directed and random stimulus for wb_queue, checked against a queue-based model.
module tb_wb_queue;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic          wb_stall;
    logic          we3;
    logic [AW-1:0] ad3;
    logic [DW-1:0] wd3;
    logic [AW-1:0] la1, la2;
    logic          hit1, hit2;
    logic [DW-1:0] hd1, hd2;
    logic [CW-1:0] count;

    wb_queue #(.ADDR_WDTH(AW), .DATA_WDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .wb_stall(wb_stall),
        .we3(we3), .ad3(ad3), .wd3(wd3),
        .la1(la1), .la2(la2),
        .hit1(hit1), .hit2(hit2), .hd1(hd1), .hd2(hd2),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t mq[$];
    int   tests = 0;
    int   fails = 0;
    int   writes = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Youngest matching pending entry wins; register 0 never forwards.
    task automatic lookup(input logic [AW-1:0] la, output logic h, output logic [DW-1:0] d);
        h = 1'b0;
        d = '0;
`ifdef WB_QUEUE_BYPASS_EN
        for (int i = 0; i < mq.size(); i++) begin
            if (la != '0 && mq[i].a == la) begin
                h = 1'b1;
                d = mq[i].d;
            end
        end
`endif
    endtask

    // Inputs are already driven; check mid-cycle, then advance model and clock together.
    task automatic cyc(input string tag);
        logic          eh1, eh2;
        logic [DW-1:0] ed1, ed2;
        int            n;
        bit            pop, push;
        #4;
        n = mq.size();
        chk({tag, ".req_ready"}, req_ready, n != DEPTH);
        chk({tag, ".we3"}, we3, (n != 0) && !wb_stall);
        chk({tag, ".ad3"}, ad3, n != 0 ? mq[0].a : '0);
        chk({tag, ".wd3"}, wd3, n != 0 ? mq[0].d : '0);
        chk({tag, ".count"}, count, n);
        lookup(la1, eh1, ed1);
        lookup(la2, eh2, ed2);
        chk({tag, ".hit1"}, hit1, eh1);
        chk({tag, ".hd1"}, hd1, ed1);
        chk({tag, ".hit2"}, hit2, eh2);
        chk({tag, ".hd2"}, hd2, ed2);
        pop  = (n != 0) && !wb_stall;
        push = req_valid && (n != DEPTH) && (req_addr != '0);
        if (pop) begin
            void'(mq.pop_front());
            writes++;
        end
        if (push) mq.push_back('{a: req_addr, d: req_data});
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic s);
        req_valid = v;
        req_addr  = a;
        req_data  = d;
        wb_stall  = s;
    endtask

    initial begin
        int w0;
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0);
        la1 = '0;
        la2 = '0;
        #12;
        chk("rst.count", count, 0);
        chk("rst.we3", we3, 0);
        chk("rst.ready", req_ready, 1);
        chk("rst.ad3", ad3, 0);
        chk("rst.wd3", wd3, 0);
        chk("rst.hit1", hit1, 0);
        chk("rst.hd2", hd2, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // single request
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
        cyc("single.acc");
        drive(1'b0, '0, '0, 1'b0);
        chk("single.we3", we3, 1);
        chk("single.ad3", ad3, 5);
        chk("single.wd3", wd3, 32'hDEADBEEF);
        cyc("single.wr");
        chk("single.done.we3", we3, 0);
        chk("single.done.count", count, 0);
        cyc("single.idle");

        // fill under stall, fifth held, then drain
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, AW'(i), DW'(i * 32'h11), 1'b1);
            cyc("fill");
        end
        chk("full.count", count, 4);
        chk("full.ready", req_ready, 0);
        drive(1'b1, 5'd9, 32'h99, 1'b1);
        cyc("full.held");
        drive(1'b1, 5'd9, 32'h99, 1'b0);
        cyc("drain.first");
        chk("drain.ready", req_ready, 1);
        drive(1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 6; i++) cyc("drain");

        // register 0 is dropped
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0);
        cyc("zero.acc");
        drive(1'b0, '0, '0, 1'b0);
        chk("zero.count", count, 0);
        chk("zero.we3", we3, 0);
        cyc("zero.after");

        // forwarding: youngest of two matches
        drive(1'b1, 5'd7, 32'h1, 1'b1);
        cyc("fwd.a");
        drive(1'b1, 5'd7, 32'h2, 1'b1);
        cyc("fwd.b");
        drive(1'b0, '0, '0, 1'b1);
        la1 = 5'd7;
        la2 = 5'd8;
        cyc("fwd.look");
        la2 = 5'd0;
        cyc("fwd.zero");
        drive(1'b0, '0, '0, 1'b0);
        cyc("fwd.pop1");
        cyc("fwd.pop2");
        la1 = '0;

        // reset mid-operation discards pending writes
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, AW'(i + 10), DW'(i), 1'b1);
            cyc("pre_rst");
        end
        drive(1'b0, '0, '0, 1'b1);
        rst = 1'b1;
        #2;
        chk("midrst.count", count, 0);
        chk("midrst.we3", we3, 0);
        chk("midrst.ready", req_ready, 1);
        mq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 4; i++) cyc("post_rst");

        // streaming: count stays 0/1, pointers wrap
        w0 = writes;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, AW'((i % 7) + 1), DW'(i + 1), 1'b0);
            cyc("stream");
            chk("stream.count_le1", count <= 1, 1);
        end
        drive(1'b0, '0, '0, 1'b0);
        cyc("stream.tail");
        chk("stream.writes", writes - w0, 10);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 2) == 0);
            if (mq.size() > 0 && $urandom_range(0, 1) == 1)
                la1 = mq[$urandom_range(0, mq.size() - 1)].a;
            else
                la1 = AW'($urandom_range(0, 7));
            la2 = AW'($urandom_range(0, 7));
            cyc("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 The block SHALL have parameter ADDR_WDTH, default 5, register address width.
REQ-002 The block SHALL have parameter DATA_WDTH, default 32, register data width.
REQ-003 The block SHALL have parameter DEPTH, default 4, number of pending write-back entries (power of two, >=2).
REQ-004 The block SHALL have port clk  input  1  single clock; all state changes on posedge.
REQ-005 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port req_valid  input  1  producer offers a write-back.
REQ-007 The block SHALL have port req_ready  output  1  queue accepts a write-back this cycle.
REQ-008 The block SHALL have port req_addr  input  ADDR_WDTH  destination register.
REQ-009 The block SHALL have port req_data  input  DATA_WDTH  result to write.
REQ-010 The block SHALL have port wb_stall  input  1  hold the write port idle this cycle.
REQ-011 The block SHALL have port we3  output  1  register file write enable.
REQ-012 The block SHALL have port ad3  output  ADDR_WDTH  register file write address.
REQ-013 The block SHALL have port wd3  output  DATA_WDTH  register file write data.
REQ-014 The block SHALL have ports la1, la2  input  ADDR_WDTH each  read addresses to check against pending writes.
REQ-015 The block SHALL have ports hit1, hit2  output  1 each  pending write exists for la1/la2.
REQ-016 The block SHALL have ports hd1, hd2  output  DATA_WDTH each  youngest pending data for la1/la2.
REQ-017 The block SHALL have port count  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-018 Enqueue SHALL occur at a posedge when req_valid && req_ready, writing {req_addr, req_data} at the tail.
REQ-019 req_ready SHALL equal (count != DEPTH), combinational from state only; no enqueue-when-full even if a pop occurs that cycle.
REQ-020 A request with req_addr == 0 SHALL be handshaked (consumed) but not stored; count unchanged by it.
REQ-021 we3 SHALL equal (count != 0) && !wb_stall; ad3/wd3 SHALL present the head entry combinationally.
REQ-022 The head SHALL be popped at each posedge where we3 is 1; exactly one write per cycle, strict FIFO order.
REQ-023 Latency: a request accepted into an empty queue at edge N SHALL drive we3=1 throughout cycle N+1 (written at edge N+1 by the register file).
REQ-024 Simultaneous enqueue and pop SHALL leave count unchanged; head/tail pointers SHALL wrap modulo DEPTH.
REQ-025 When count == 0, ad3 and wd3 SHALL be 0.
REQ-026 wb_stall SHALL not affect req_ready or enqueue.

Reset
REQ-027 On rst assertion, asynchronously: count=0, pointers=0, we3=0, ad3=0, wd3=0, req_ready=1, hit1=hit2=0, hd1=hd2=0.
REQ-028 Reset mid-operation SHALL discard all pending entries; no write SHALL be issued for them after rst deasserts.
REQ-029 Entry storage contents need not be reset; only valid state is reset.

Configuration
REQ-030 Macro WB_QUEUE_BYPASS_EN SHALL control lookup forwarding.
REQ-031 With WB_QUEUE_BYPASS_EN defined: hitN=1 when any occupied entry has addr == laN and laN != 0; hdN = data of the youngest matching entry (closest to tail); else hitN=0, hdN=0; purely combinational.
REQ-032 Without WB_QUEUE_BYPASS_EN: ports la1/la2/hit1/hit2/hd1/hd2 SHALL still exist; hit1=hit2=0 and hd1=hd2=0 constantly; no comparator logic.
REQ-033 An entry being popped in the current cycle SHALL still count as pending for lookup.

Verification
REQ-034 Reset, single request addr=5 data=0xDEADBEEF -> next cycle we3=1, ad3=5, wd3=0xDEADBEEF; following cycle we3=0, count=0.
REQ-035 wb_stall=1, enqueue 4 requests (addr 1..4, data 0x11..0x44) -> count=4, req_ready=0, 5th request held; release stall -> writes 1,2,3,4 on consecutive cycles, req_ready=1 after first pop.
REQ-036 Request addr=0 data=0xFFFFFFFF -> req_ready=1, count stays 0, we3 never asserted.
REQ-037 BYPASS_EN, stall, enqueue addr 7 data 0x1 then addr 7 data 0x2, la1=7, la2=8 -> hit1=1, hd1=0x2, hit2=0, hd2=0; without macro -> hit1=0, hd1=0.
REQ-038 Queue count=3 with stall, assert rst for one cycle -> count=0, we3=0 immediately; release stall -> no writes issued.
REQ-039 Continuous req_valid with wb_stall=0 for 10 cycles, data incrementing -> count toggles 0/1 only, 10 in-order writes, pointers wrap without loss.
